pe_stream_rd_dma: RTL
=====================

PE_STREAM_RD_DMA -- requirements
Module: pe_stream_rd_dma

Interface
REQ-001 Parameter DATA_W, default 32, width of a memory word and of a lane word.
REQ-002 Parameter ADDR_W, default 24, word-address width.
REQ-003 Parameter LEN_W, default 12, descriptor word-count width.
REQ-004 Parameter FIFO_DEPTH, default 8, return-data buffer depth; SHALL be a power of two and at least 2.
REQ-005 clk  in  1  the single clock; all logic SHALL be rising-edge triggered on it.
REQ-006 reset_poweron  in  1  reset, asynchronous assert, active-high.
REQ-007 desc_valid  in  1  stream-operation controller presents a read descriptor.
REQ-008 desc_ready  out  1  block accepts a descriptor.
REQ-009 desc_addr  in  ADDR_W  start word address.
REQ-010 desc_len  in  LEN_W  number of words to read; 0 means a no-op descriptor.
REQ-011 mem_req_valid  out  1  read request to the PE memory.
REQ-012 mem_req_ready  in  1  memory accepts the request.
REQ-013 mem_req_addr  out  ADDR_W  request word address.
REQ-014 mem_rsp_valid  in  1  read data returning, in order, with no backpressure.
REQ-015 mem_rsp_data  in  DATA_W  returned word.
REQ-016 lane_valid  out  1  word offered to the downstream lane.
REQ-017 lane_ready  in  1  lane accepts the word.
REQ-018 lane_data  out  DATA_W  lane word.
REQ-019 lane_eom  out  1  end-of-message; SHALL be high with the final word of a descriptor.
REQ-020 busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE and DRAIN.
REQ-022 IDLE: desc_ready=1; on desc_valid&desc_ready, latch addr/len; len>0 -> ISSUE, len=0 -> DRAIN.
REQ-023 desc_ready SHALL be 0 in ISSUE and DRAIN; only one descriptor is in flight at a time.
REQ-024 ISSUE: mem_req_valid=1 iff credit is available, where credit means outstanding requests plus FIFO occupancy is less than FIFO_DEPTH.
REQ-025 First mem_req_valid SHALL be asserted the cycle after descriptor acceptance (1-cycle latency).
REQ-026 mem_req_valid, once high, SHALL hold with a stable mem_req_addr until mem_req_ready.
REQ-027 Each accepted request SHALL increment the address by 1 modulo 2^ADDR_W (wrap from all-ones to 0) and decrement the remaining count.
REQ-028 When the last request is accepted, the FSM SHALL go ISSUE -> DRAIN.
REQ-029 mem_rsp_valid SHALL push mem_rsp_data into the FIFO and decrement the outstanding count; overflow is impossible by credit and SHALL be flagged by an assertion.
REQ-030 lane_valid SHALL be asserted whenever the FIFO is non-empty, with lane_data = FIFO head; there is 1 cycle of latency from mem_rsp_valid to lane_valid.
REQ-031 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; a push into a full FIFO that is also popping SHALL be legal.
REQ-032 lane_eom SHALL be 1 only on the word whose delivered count equals the latched len.
REQ-033 DRAIN -> IDLE SHALL occur the cycle after the final lane handshake; for len=0, DRAIN -> IDLE occurs in the next cycle with no lane activity.
REQ-034 The outstanding counter SHALL be wide enough for FIFO_DEPTH; a request accept and a response in the same cycle SHALL leave it unchanged.

Reset
REQ-035 Reset SHALL force: state IDLE, busy=0, desc_ready=0 while asserted and 1 after release, mem_req_valid=0, lane_valid=0, lane_eom=0, and all counters and FIFO pointers to 0.
REQ-036 Reset mid-operation SHALL abandon the descriptor; the memory is reset by the same reset_poweron, so no stale responses arrive.

Verification
REQ-037 addr=0x000010, len=4, mem_req_ready=1, memory latency 2, lane_ready=1 -> requests 0x10..0x13 in consecutive cycles; 4 lane words in order; eom on the 4th only.
REQ-038 len=0 -> desc accepted; busy high for exactly 1 cycle; no mem_req_valid or lane_valid.
REQ-039 addr=0xFFFFFE, len=4 -> request addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-040 len=20, lane_ready=0 -> exactly 8 requests issued, then stall; after lane_ready=1, all 20 words are delivered and occupancy never exceeds 8.
REQ-041 Random mem_req_ready/lane_ready toggling, len=37 -> data matches memory in order; address stable while stalled; exactly one eom.
REQ-042 Assert reset_poweron after the 3rd word of a len=10 read -> all outputs at reset values within the same cycle; a new descriptor after release is processed correctly.

Source files
------------

// File: rtl/pe_stream_rd_dma.sv
// Read DMA for the PE stream path: turns one (addr, len) descriptor into a burst of memory reads
// and streams the in-order responses to a downstream lane through a credit-managed FIFO.
module pe_stream_rd_dma #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned LEN_W      = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              lane_valid,
  input  logic              lane_ready,
  output logic [DATA_W-1:0] lane_data,
  output logic              lane_eom,
  output logic              busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthWide = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  delivered_q, delivered_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic            desc_fire, req_fire, push, pop;
  logic            credit, fifo_full;
  logic [CntW:0]   in_use;

  // Outstanding reads plus buffered words bound what may still land in the FIFO, so a request
  // is only offered while that sum leaves room.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign credit    = (in_use < DepthWide);
  assign fifo_full = (fifo_cnt_q == DepthCnt);

  assign desc_ready    = (state_q == StIdle) && !reset_poweron;
  assign mem_req_valid = (state_q == StIssue) && credit;
  assign mem_req_addr  = addr_q;
  assign lane_valid    = (fifo_cnt_q != '0);
  assign lane_data     = fifo_mem[rd_ptr_q];
  assign lane_eom      = lane_valid && ((delivered_q + LEN_W'(1)) == len_q);
  assign busy          = (state_q != StIdle);

  assign desc_fire = desc_valid && desc_ready;
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign push      = mem_rsp_valid;
  assign pop       = lane_valid && lane_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    len_d       = len_q;
    delivered_d = pop ? (delivered_q + LEN_W'(1)) : delivered_q;

    unique case (state_q)
      StIdle: begin
        if (desc_fire) begin
          addr_d      = desc_addr;
          len_d       = desc_len;
          remain_d    = desc_len;
          delivered_d = '0;
          state_d     = (desc_len != '0) ? StIssue : StDrain;
        end
      end
      StIssue: begin
        if (req_fire) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Covers the zero-length descriptor too: nothing to deliver, leave next cycle.
        if (delivered_d == len_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(push);
    fifo_cnt_d    = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remain_q      <= '0;
      len_q         <= '0;
      delivered_q   <= '0;
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      len_q         <= len_d;
      delivered_q   <= delivered_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Data storage needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rsp_data;
    end
  end

  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (reset_poweron)
    !(push && fifo_full && !pop));

  rsp_has_request_a: assert property (@(posedge clk) disable iff (reset_poweron)
    !(push && (outstanding_q == '0)));

  req_held_a: assert property (@(posedge clk) disable iff (reset_poweron)
    (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_req_addr)));

endmodule
